// File: rtl/pipe_stage_reg.sv
// Two-entry skid-buffered pipeline stage register with valid/ready handshake.
// in_ready, out_valid and occupancy are registered copies of the state, so no
// combinational path runs from out_ready to in_ready. out_ctrl reads as zero
// whenever the stage is empty, so a bubble never asserts downstream enables.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [CTRL_W-1:0] skid_ctrl;

    logic in_acc;
    logic out_acc;

    // Handshake events for this cycle
    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    // Main entry drives the outputs; main_ctrl is kept zero whenever empty
    assign out_data = main_data;
    assign out_ctrl = main_ctrl;

    // State machine, storage and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else if (flush) begin
            // Discard everything, including any entry offered this cycle
            state     <= EMPTY;
            main_ctrl <= '0;
            skid_ctrl <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_acc) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                        state     <= ONE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                ONE: begin
                    if (in_acc && out_acc) begin
                        main_data <= in_data;
                        main_ctrl <= in_ctrl;
                    end else if (in_acc) begin
                        skid_data <= in_data;
                        skid_ctrl <= in_ctrl;
                        state     <= TWO;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        occupancy <= 2'd2;
                    end else if (out_acc) begin
                        // Leave main_data as-is so out_data holds its last value
                        main_ctrl <= '0;
                        state     <= EMPTY;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        occupancy <= 2'd0;
                    end
                end
                TWO: begin
                    if (out_acc) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                        skid_ctrl <= '0;
                        state     <= ONE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b1;
                        occupancy <= 2'd1;
                    end
                end
                default: begin
                    main_ctrl <= '0;
                    skid_ctrl <= '0;
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    occupancy <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks for the pipe_stage_reg skid-buffer stage.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 8;

    logic              clk;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    int tests;
    int fails;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge; inputs are driven and outputs sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;
        #3;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0 ||
            out_ctrl !== 8'h00 || out_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b vld=%b occ=%0d ctrl=%h data=%h, want 1 0 0 00 00000000",
                     in_ready, out_valid, occupancy, out_ctrl, out_data);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_single();
        in_data = 32'h0000_1234; in_ctrl = 8'h81; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_1234 || out_ctrl !== 8'h81) begin
            fails++;
            $display("FAIL single_out: got vld=%b data=%h ctrl=%h, want 1 00001234 81",
                     out_valid, out_data, out_ctrl);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || out_data !== 32'h0000_1234) begin
            fails++;
            $display("FAIL single_bubble: got vld=%b ctrl=%h data=%h, want 0 00 00001234",
                     out_valid, out_ctrl, out_data);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = 32'(i); in_ctrl = 8'(i); in_valid = 1'b1;
            step();
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'(i) || out_ctrl !== 8'(i) ||
                occupancy !== 2'd1 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL stream_%0d: got vld=%b data=%h ctrl=%h occ=%0d rdy=%b, want 1 %h %h 1 1",
                         i, out_valid, out_data, out_ctrl, occupancy, in_ready, 32'(i), 8'(i));
            end
        end
        in_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
            fails++;
            $display("FAIL stream_drain: got vld=%b occ=%0d, want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_data = 32'hAAAA_0001; in_ctrl = 8'h0A; in_valid = 1'b1;
        step();
        tests++;
        if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 32'hAAAA_0001) begin
            fails++;
            $display("FAIL bp_one: got occ=%0d rdy=%b data=%h, want 1 1 aaaa0001",
                     occupancy, in_ready, out_data);
        end
        in_data = 32'hBBBB_0002; in_ctrl = 8'h0B;
        step();
        tests++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hAAAA_0001 ||
            out_ctrl !== 8'h0A) begin
            fails++;
            $display("FAIL bp_two: got occ=%0d rdy=%b data=%h ctrl=%h, want 2 0 aaaa0001 0a",
                     occupancy, in_ready, out_data, out_ctrl);
        end
        in_data = 32'hCCCC_0003; in_ctrl = 8'h0C;
        step();
        tests++;
        if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hAAAA_0001) begin
            fails++;
            $display("FAIL bp_hold: got occ=%0d rdy=%b data=%h, want 2 0 aaaa0001",
                     occupancy, in_ready, out_data);
        end
        out_ready = 1'b1;
        step();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hBBBB_0002 || out_ctrl !== 8'h0B ||
            occupancy !== 2'd1) begin
            fails++;
            $display("FAIL bp_B: got vld=%b data=%h ctrl=%h occ=%0d, want 1 bbbb0002 0b 1",
                     out_valid, out_data, out_ctrl, occupancy);
        end
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hCCCC_0003 || out_ctrl !== 8'h0C) begin
            fails++;
            $display("FAIL bp_C: got vld=%b data=%h ctrl=%h, want 1 cccc0003 0c",
                     out_valid, out_data, out_ctrl);
        end
        step();
        tests++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 8'h00) begin
            fails++;
            $display("FAIL bp_empty: got vld=%b occ=%0d ctrl=%h, want 0 0 00",
                     out_valid, occupancy, out_ctrl);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 32'hDDDD_0004; in_ctrl = 8'h0D;
        step();
        in_data = 32'hEEEE_0005; in_ctrl = 8'h0E;
        step();
        flush = 1'b1; in_data = 32'hFFFF_0006; in_ctrl = 8'h0F;
        step();
        flush = 1'b0; in_valid = 1'b0;
        tests++;
        if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_two: got occ=%0d vld=%b ctrl=%h rdy=%b, want 0 0 00 1",
                     occupancy, out_valid, out_ctrl, in_ready);
        end
        out_ready = 1'b1;
        step();
        step();
        tests++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
            fails++;
            $display("FAIL flush_discard: got vld=%b ctrl=%h, want 0 00", out_valid, out_ctrl);
        end
        // Flush in EMPTY beats a simultaneous input accept
        flush = 1'b1; in_valid = 1'b1; in_data = 32'h1111_2222; in_ctrl = 8'h55;
        step();
        flush = 1'b0; in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 8'h00) begin
            fails++;
            $display("FAIL flush_empty: got vld=%b occ=%0d ctrl=%h, want 0 0 00",
                     out_valid, occupancy, out_ctrl);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 32'h1357_0001; in_ctrl = 8'h31;
        step();
        in_data = 32'h1357_0002; in_ctrl = 8'h32;
        step();
        in_valid = 1'b0;
        tests++;
        if (occupancy !== 2'd2) begin
            fails++;
            $display("FAIL areset_fill: got occ=%0d, want 2", occupancy);
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 ||
            occupancy !== 2'd0 || out_ctrl !== 8'h00) begin
            fails++;
            $display("FAIL areset_mid: got vld=%b rdy=%b data=%h occ=%0d ctrl=%h, want 0 1 00000000 0 00",
                     out_valid, in_ready, out_data, occupancy, out_ctrl);
        end
        step();
        reset = 1'b0;
        // First edge after release accepts an entry
        in_valid = 1'b1; in_data = 32'h0BAD_F00D; in_ctrl = 8'h77; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h0BAD_F00D || out_ctrl !== 8'h77) begin
            fails++;
            $display("FAIL areset_first: got vld=%b data=%h ctrl=%h, want 1 0badf00d 77",
                     out_valid, out_data, out_ctrl);
        end
        step();
    endtask

    task automatic test_random();
        logic [CTRL_W+DATA_W-1:0] q[$];
        logic [CTRL_W+DATA_W-1:0] exp;
        int rnd_fails;
        bit do_in;
        bit do_out;
        rnd_fails = 0;
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            in_data   = $urandom;
            in_ctrl   = 8'($urandom);
            #1;
            tests++;
            if (in_ready !== (q.size() < 2) || out_valid !== (q.size() > 0) ||
                occupancy !== 2'(q.size()) || (!out_valid && out_ctrl !== 8'h00)) begin
                fails++;
                if (rnd_fails < 10)
                    $display("FAIL rand_status_%0d: got rdy=%b vld=%b occ=%0d ctrl=%h, want model size %0d and ctrl 00 when empty",
                             c, in_ready, out_valid, occupancy, out_ctrl, q.size());
                rnd_fails++;
            end
            do_in  = (q.size() < 2) && in_valid;
            do_out = (q.size() > 0) && out_ready;
            if (do_out) begin
                exp = q.pop_front();
                tests++;
                if ({out_ctrl, out_data} !== exp) begin
                    fails++;
                    if (rnd_fails < 10)
                        $display("FAIL rand_order_%0d: got %h_%h, want %h_%h",
                                 c, out_ctrl, out_data, exp[CTRL_W+DATA_W-1:DATA_W], exp[DATA_W-1:0]);
                    rnd_fails++;
                end
            end
            if (do_in) q.push_back({in_ctrl, in_data});
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the datapath payload (result, memory data, PC+4, immediate and similar fields).
REQ-002 Parameter CTRL_W, default 8, width of the control payload (reg_write, mem_to_reg, write register and similar fields).
REQ-003 Port clk  input  1  clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port flush  input  1  synchronous discard of all held entries.
REQ-006 Port in_valid  input  1  upstream presents an entry.
REQ-007 Port in_ready  output  1  stage can accept an entry this cycle.
REQ-008 Port in_data  input  DATA_W  upstream datapath payload.
REQ-009 Port in_ctrl  input  CTRL_W  upstream control payload.
REQ-010 Port out_valid  output  1  stage presents an entry downstream.
REQ-011 Port out_ready  input  1  downstream accepts the presented entry.
REQ-012 Port out_data  output  DATA_W  presented datapath payload.
REQ-013 Port out_ctrl  output  CTRL_W  presented control payload.
REQ-014 Port occupancy  output  2  number of held entries, 0..2.

Function
REQ-015 Input accept = in_valid & in_ready; output accept = out_valid & out_ready.
REQ-016 Storage is two entries, main (drives outputs) and skid; each holds data and ctrl.
REQ-017 State machine has three states, EMPTY, ONE and TWO, and occupancy equals 0, 1 or 2 respectively.
REQ-018 in_ready shall be 1 in EMPTY and ONE and 0 in TWO; it is a registered function of state and has no combinational path from out_ready.
REQ-019 out_valid shall be 1 in ONE and TWO, and 0 in EMPTY.
REQ-020 EMPTY with input accept: main loads the input and the state goes to ONE.
REQ-021 ONE with input accept and output accept: main loads the input and the state stays ONE.
REQ-022 ONE with input accept and no output accept: skid loads the input and the state goes to TWO.
REQ-023 ONE with output accept and no input accept: the state goes to EMPTY.
REQ-024 TWO with output accept: main loads skid and the state goes to ONE.
REQ-025 Any state with no accept event holds all entries unchanged (stall).
REQ-026 Entries leave in exactly the order they were accepted; there is no loss or duplication absent flush.
REQ-027 Latency is one cycle from input accept in EMPTY to out_valid=1; sustained throughput is one entry per cycle while out_ready=1.
REQ-028 out_data shall equal main data and out_ctrl shall equal main ctrl while out_valid=1.
REQ-029 out_ctrl shall be forced to all-zero while out_valid=0, so a bubble never asserts write enables.
REQ-030 While out_valid=0, out_data holds its last value.
REQ-031 flush=1 forces the state to EMPTY and clears main ctrl and skid ctrl to zero at the next edge, regardless of in_valid and out_ready.
REQ-032 Flush has priority over a simultaneous input accept, and that input entry is discarded.
REQ-033 An output accept in the same cycle as flush counts as consumed by downstream.
REQ-034 No internal arithmetic depends on DATA_W or CTRL_W, and both parameters are supported for any value of 1 or more.

Reset
REQ-035 On reset assertion, without waiting for clk, state shall be EMPTY, in_ready=1, out_valid=0, occupancy=0, out_ctrl=0 and out_data=0.
REQ-036 Both storage entries clear to zero on reset.
REQ-037 Reset asserted mid-operation discards all held entries immediately.
REQ-038 After reset deasserts, the first rising edge may accept an input.

Verification
REQ-039 Scenario: reset, then in_data=0x0000_1234, in_ctrl=0x81, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x0000_1234, out_ctrl=0x81, then out_valid=0 and out_ctrl=0x00.
REQ-040 Scenario: stream values 1..8 with out_ready=1 -> outputs 1..8 on consecutive cycles, occupancy stays 1, in_ready stays 1.
REQ-041 Scenario: hold out_ready=0 and offer A and B -> occupancy=2 and in_ready=0; a third value C is held off; raise out_ready -> outputs A, B, C in order with no loss.
REQ-042 Scenario: occupancy=2, assert flush with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_ctrl=0x00, and the offered entry never appears.
REQ-043 Scenario: assert reset asynchronously mid-cycle at occupancy=2 -> out_valid=0, in_ready=1, out_data=0 before the next clk edge.
REQ-044 Scenario: random in_valid and out_ready for 10k cycles against a scoreboard queue -> order preserved, occupancy never exceeds 2, out_ctrl=0 whenever out_valid=0.
